// File: rtl/square_lock_ctrl.sv
// Three-square colour lock: debounced presses advance per-square steps through a
// round-robin grant; a sustained full match unlocks for a fixed time, then relocks.
module square_lock_ctrl #(
  parameter int NUM_STEPS     = 5,
  parameter int TARGET        = 3,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int UNLOCK_CYCLES = 300_000_000,
  parameter int BLINK_DIV     = 12_500_000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       up_pulse,
  input  logic       centre_pulse,
  input  logic       down_pulse,
  output logic [2:0] step_top,
  output logic [2:0] step_mid,
  output logic [2:0] step_bot,
  output logic [1:0] state_o,
  output logic       unlocked,
  output logic       blink
);

  localparam int MAX_HU = (HOLD_CYCLES > UNLOCK_CYCLES) ? HOLD_CYCLES : UNLOCK_CYCLES;
  localparam int MAX_P  = (MAX_HU > BLINK_DIV) ? MAX_HU : BLINK_DIV;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_CYCLES - 1);
  localparam logic [CW-1:0] BLINK_LAST  = CW'(BLINK_DIV - 1);
  localparam logic [2:0]    STEP_LAST   = 3'(NUM_STEPS - 1);
  localparam logic [2:0]    TARGET_V    = 3'(TARGET);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_BAD      = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      pending_reg, pending_next;
  logic [1:0]      ptr_reg, ptr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [CW-1:0]   blink_cnt_reg, blink_cnt_next;
  logic            blink_reg, blink_next;
  logic            relock;
  logic            clear_pend;
  logic            grant_en;
  logic [2:0]      grant;
  logic [2:0]      pulses;
  logic [2:0][2:0] step_vec;
  logic            all_match;

  // Bit 0 = top, 1 = mid, 2 = bot; ptr is the first square searched this cycle.
  function automatic logic [2:0] rr_grant(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] g;
    logic [1:0] idx;
    int         t;
    g = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      t = int'(ptr) + k;
      if (t >= 3) t = t - 3;
      idx = 2'(t);
      if (req[idx]) g = 3'b001 << idx;
    end
    return g;
  endfunction

  assign pulses    = {down_pulse, centre_pulse, up_pulse};
  assign grant_en  = (state_reg == ST_IDLE) || (state_reg == ST_HOLD);
  assign grant     = grant_en ? rr_grant(pending_reg, ptr_reg) : 3'b000;
  assign all_match = (step_vec == {3{TARGET_V}});

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_sq
      logic [2:0] step_reg, step_next;

      always_comb begin
        step_next = step_reg;
        if (relock)
          step_next = 3'd0;
        else if (grant[gi])
          step_next = (step_reg == STEP_LAST) ? 3'd0 : step_reg + 3'd1;
      end

      always_ff @(posedge CLOCK) begin
        if (RESET) step_reg <= 3'd0;
        else       step_reg <= step_next;
      end

      assign step_vec[gi] = step_reg;
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    blink_next     = blink_reg;
    blink_cnt_next = blink_cnt_reg;
    relock         = 1'b0;
    clear_pend     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next       = '0;
        blink_next     = 1'b0;
        blink_cnt_next = '0;
        if (all_match && (pending_reg == 3'b000)) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (|grant) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next     = ST_UNLOCKED;
          cnt_next       = '0;
          blink_next     = 1'b1;
          blink_cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_UNLOCKED: begin
        clear_pend = 1'b1;
        if (cnt_reg == UNLOCK_LAST) begin
          state_next     = ST_IDLE;
          cnt_next       = '0;
          relock         = 1'b1;
          blink_next     = 1'b0;
          blink_cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (blink_cnt_reg == BLINK_LAST) begin
            blink_next     = ~blink_reg;
            blink_cnt_next = '0;
          end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next     = ST_IDLE;
        cnt_next       = '0;
        blink_next     = 1'b0;
        blink_cnt_next = '0;
        clear_pend     = 1'b1;
      end
    endcase
  end

  // Clearing before OR-ing lets a press re-arm the bit in the cycle it is granted.
  always_comb begin
    pending_next = clear_pend ? 3'b000 : ((pending_reg & ~grant) | pulses);
    case (grant)
      3'b001:  ptr_next = 2'd1;
      3'b010:  ptr_next = 2'd2;
      3'b100:  ptr_next = 2'd0;
      default: ptr_next = ptr_reg;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg     <= ST_IDLE;
      pending_reg   <= 3'b000;
      ptr_reg       <= 2'd0;
      cnt_reg       <= '0;
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      blink_reg     <= blink_next;
    end
  end

  assign step_top = step_vec[0];
  assign step_mid = step_vec[1];
  assign step_bot = step_vec[2];
  assign state_o  = state_reg;
  assign unlocked = (state_reg == ST_UNLOCKED);
  assign blink    = blink_reg;

endmodule

// File: tb/tb_square_lock_ctrl.sv
// Directed bench for square_lock_ctrl with small timing parameters; expected
// values go through a scoreboard queue and are checked with immediate assertions.
module tb_square_lock_ctrl;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       up_pulse = 1'b0;
  logic       centre_pulse = 1'b0;
  logic       down_pulse = 1'b0;
  logic [2:0] step_top, step_mid, step_bot;
  logic [1:0] state_o;
  logic       unlocked, blink;

  square_lock_ctrl #(
    .NUM_STEPS(5), .TARGET(3), .HOLD_CYCLES(4), .UNLOCK_CYCLES(16), .BLINK_DIV(2)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .up_pulse(up_pulse), .centre_pulse(centre_pulse), .down_pulse(down_pulse),
    .step_top(step_top), .step_mid(step_mid), .step_bot(step_bot),
    .state_o(state_o), .unlocked(unlocked), .blink(blink)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0d with no expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp_chk(input string tag, input logic [31:0] obs, input logic [31:0] val);
    push(tag, val);
    check(obs);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic press(input logic u, input logic c, input logic d);
    up_pulse = u; centre_pulse = c; down_pulse = d;
    tick();
    up_pulse = 1'b0; centre_pulse = 1'b0; down_pulse = 1'b0;
  endtask

  task automatic round();
    press(1'b1, 1'b1, 1'b1);
    tick(3);
  endtask

  task automatic to_match();
    do_reset();
    repeat (3) round();
    exp_chk("match_steps", {23'd0, step_bot, step_mid, step_top}, {23'd0, 3'd3, 3'd3, 3'd3});
  endtask

  task automatic reach_unlocked();
    to_match();
    tick(5);
    exp_chk("reach_unlocked", 32'(state_o), 32'd2);
  endtask

  initial begin
    // Reset state
    do_reset();
    exp_chk("rst_top", 32'(step_top), 0);
    exp_chk("rst_mid", 32'(step_mid), 0);
    exp_chk("rst_bot", 32'(step_bot), 0);
    exp_chk("rst_state", 32'(state_o), 0);
    exp_chk("rst_unlocked", 32'(unlocked), 0);
    exp_chk("rst_blink", 32'(blink), 0);

    // Five spaced up presses walk the top step through a full wrap
    for (int i = 0; i < 5; i++) begin
      push("seq_top", 32'((i + 1) % 5));
      press(1'b1, 1'b0, 1'b0);
      tick();
      check(32'(step_top));
      tick();
    end
    exp_chk("seq_mid_idle", 32'(step_mid), 0);
    exp_chk("seq_bot_idle", 32'(step_bot), 0);
    exp_chk("seq_state", 32'(state_o), 0);

    // Simultaneous presses are served top, mid, bot on consecutive cycles
    do_reset();
    push("rr_c1", {23'd0, 3'd0, 3'd0, 3'd1});
    push("rr_c2", {23'd0, 3'd0, 3'd1, 3'd1});
    push("rr_c3", {23'd0, 3'd1, 3'd1, 3'd1});
    press(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({23'd0, step_bot, step_mid, step_top});
    end

    // Full unlock cycle with blink pattern and auto-relock
    to_match();
    exp_chk("pre_hold_state", 32'(state_o), 0);
    tick();
    exp_chk("hold_entered", 32'(state_o), 1);
    tick(3);
    exp_chk("hold_cnt3", 32'(state_o), 1);
    exp_chk("hold_locked", 32'(unlocked), 0);
    tick();
    for (int k = 0; k < 16; k++) begin
      exp_chk($sformatf("unl_%0d", k), 32'(unlocked), 1);
      exp_chk($sformatf("blink_%0d", k), 32'(blink), ((k / 2) % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    exp_chk("relock_state", 32'(state_o), 0);
    exp_chk("relock_unlocked", 32'(unlocked), 0);
    exp_chk("relock_blink", 32'(blink), 0);
    exp_chk("relock_steps", {23'd0, step_bot, step_mid, step_top}, 0);

    // A press while the hold counter is 2 aborts the unlock
    to_match();
    tick(3);
    up_pulse = 1'b1;
    tick();
    up_pulse = 1'b0;
    exp_chk("abort_still_hold", 32'(state_o), 1);
    tick();
    exp_chk("abort_state", 32'(state_o), 0);
    exp_chk("abort_top", 32'(step_top), 4);
    tick(6);
    exp_chk("abort_no_unlock", 32'(unlocked), 0);
    exp_chk("abort_idle", 32'(state_o), 0);

    // Presses while unlocked are ignored, including on the relock edge
    reach_unlocked();
    for (int k = 0; k < 16; k++) begin
      exp_chk($sformatf("ign_steps_%0d", k), {23'd0, step_bot, step_mid, step_top},
              {23'd0, 3'd3, 3'd3, 3'd3});
      up_pulse     = (k % 3 == 0) || (k == 15);
      centre_pulse = (k % 4 == 1) || (k == 15);
      down_pulse   = (k % 2 == 1);
      tick();
    end
    up_pulse = 1'b0; centre_pulse = 1'b0; down_pulse = 1'b0;
    exp_chk("ign_relock_state", 32'(state_o), 0);
    tick(4);
    exp_chk("ign_no_stale_grant", {23'd0, step_bot, step_mid, step_top}, 0);

    // Reset in the middle of the unlocked window
    reach_unlocked();
    tick(5);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_chk("urst_state", 32'(state_o), 0);
    exp_chk("urst_unlocked", 32'(unlocked), 0);
    exp_chk("urst_blink", 32'(blink), 0);
    exp_chk("urst_steps", {23'd0, step_bot, step_mid, step_top}, 0);

    exp_chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/square_lock_ctrl.md
SQUARE_LOCK_CTRL -- requirements
Module: square_lock_ctrl

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 5, colour steps per square (values 0..NUM_STEPS-1, range 2..8).
REQ-002 SHALL have parameter TARGET, default 3, step value each square must hold to match (< NUM_STEPS).
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000, cycles a full match must persist before unlock (>= 1).
REQ-004 SHALL have parameter UNLOCK_CYCLES, default 300_000_000, cycles unlocked state lasts before auto-relock (>= 1).
REQ-005 SHALL have parameter BLINK_DIV, default 12_500_000, cycles per blink half-period while unlocked (>= 1).
REQ-006 SHALL have port CLOCK  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-008 SHALL have port up_pulse  input  1  single-cycle debounced press, top square.
REQ-009 SHALL have port centre_pulse  input  1  single-cycle debounced press, middle square.
REQ-010 SHALL have port down_pulse  input  1  single-cycle debounced press, bottom square.
REQ-011 SHALL have port step_top  output  3  current step, top square.
REQ-012 SHALL have port step_mid  output  3  current step, middle square.
REQ-013 SHALL have port step_bot  output  3  current step, bottom square.
REQ-014 SHALL have port state_o  output  2  FSM state: 0 IDLE, 1 HOLD, 2 UNLOCKED.
REQ-015 SHALL have port unlocked  output  1  high exactly while state is UNLOCKED.
REQ-016 SHALL have port blink  output  1  indicator toggle, 0 outside UNLOCKED.

Function
REQ-017 SHALL hold one pending bit per square; a pulse sets its bit in the same edge; a pulse on an already-set bit is dropped.
REQ-018 SHALL grant at most one pending bit per cycle, round-robin order top->mid->bot, search starting after the last granted square (initially top first).
REQ-019 SHALL, on grant, clear that pending bit and increment that square's step by 1, wrapping NUM_STEPS-1 -> 0; one-cycle latency from pending set to step update.
REQ-020 SHALL allow a new pulse on a square in the same cycle its bit is granted; the new pulse re-sets the bit.
REQ-021 SHALL, in IDLE, enter HOLD when all three steps equal TARGET and no bit is pending; hold counter loaded 0.
REQ-022 SHALL, in HOLD, increment the hold counter each cycle with no grant; on any grant return to IDLE and clear the counter.
REQ-023 SHALL, in HOLD, enter UNLOCKED when the hold counter reaches HOLD_CYCLES-1 with no grant that cycle.
REQ-024 SHALL, in UNLOCKED, clear and ignore all pulses and pending bits, and perform no grants.
REQ-025 SHALL, in UNLOCKED, toggle blink every BLINK_DIV cycles, starting at 1 on entry.
REQ-026 SHALL, after UNLOCK_CYCLES cycles in UNLOCKED, return to IDLE, set all steps to 0, and drive blink 0.
REQ-027 SHALL size internal counters to $clog2 of the larger parameter; no counter overflow for any legal parameter.
REQ-028 SHALL never leave state_o at value 3; if reached, next cycle is IDLE.

Reset
REQ-029 SHALL, with RESET high at a rising edge, set all steps 0, pending bits 0, counters 0, round-robin pointer to top, state IDLE, unlocked 0, blink 0.
REQ-030 SHALL give RESET priority over every pulse and state transition, including mid-HOLD and mid-UNLOCKED.

Verification (bench params NUM_STEPS=5, TARGET=3, HOLD_CYCLES=4, UNLOCK_CYCLES=16, BLINK_DIV=2)
REQ-031 SHALL cover: 5 up_pulses spaced 3 cycles -> step_top 1,2,3,4,0; other steps stay 0.
REQ-032 SHALL cover: up, centre, down pulses same cycle -> step_top, step_mid, step_bot increment on 3 consecutive cycles in that order.
REQ-033 SHALL cover: 3 presses each square, then idle -> HOLD entered, unlocked=1 4 cycles later, blink 1,1,0,0,..., auto-relock after 16 cycles with all steps 0.
REQ-034 SHALL cover: in HOLD at counter 2, one up_pulse -> state IDLE, step_top=4, no unlock.
REQ-035 SHALL cover: pulses during UNLOCKED -> steps unchanged; pending bits 0 at relock.
REQ-036 SHALL cover: RESET asserted one cycle in UNLOCKED -> next cycle IDLE, unlocked 0, blink 0, all steps 0.
